// File: rtl/adc_rec.sv
// I2S left-channel recorder: captures 16-bit left samples into consecutive SRAM words.
// Strobe one bclk after the LSB, addr steps on the next edge; no backpressure, bus released while record=0.
module adc_rec (
  input  logic        bclk,
  input  logic        reset,
  input  logic        record,
  input  logic        adclrc,
  input  logic        adcdat,
  output logic [17:0] addr,
  output logic [15:0] data,
  output logic        write,
  output logic        full
);

  typedef enum logic [2:0] {IDLE, SYNC, SKIP, SHIFT, STORE, WAIT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [17:0] addr_q;
  logic [15:0] shift_q;
  logic [3:0]  bit_cnt;
  logic        lrc_q;
  logic        frame_start;

  assign frame_start = lrc_q & ~adclrc;

  always_ff @(posedge bclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!record) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (!full) state_nxt = SYNC;
        SYNC:  if (frame_start) state_nxt = SKIP;
        SKIP:  state_nxt = SHIFT;
        // a new left frame before 16 bits means the previous one was short
        SHIFT: if (frame_start)            state_nxt = SKIP;
               else if (bit_cnt == 4'd15)  state_nxt = STORE;
        STORE: state_nxt = (addr_q == 18'h3FFFF) ? IDLE : WAIT;
        WAIT:  state_nxt = SYNC;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    write = 1'b0;
    if (state == STORE && record && !full && !reset) write = 1'b1;
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      addr_q  <= 18'd0;
      shift_q <= 16'd0;
      bit_cnt <= 4'd0;
      full    <= 1'b0;
      lrc_q   <= 1'b1;
    end else begin
      lrc_q <= adclrc;
      if (state == SKIP) bit_cnt <= 4'd0;
      if (state == SHIFT && record) begin
        shift_q <= {shift_q[14:0], adcdat};
        bit_cnt <= bit_cnt + 4'd1;
      end
      // last word is sticky: flag full instead of wrapping over old samples
      if (write) begin
        if (addr_q == 18'h3FFFF) full   <= 1'b1;
        else                     addr_q <= addr_q + 18'd1;
      end
    end
  end

  assign addr = record ? addr_q  : 'z;
  assign data = record ? shift_q : 'z;

endmodule

// File: tb/tb_adc_rec.sv
// Directed bench for adc_rec: I2S frames in, expected SRAM writes from a queue-based recorder model.
module tb_adc_rec;

  logic        bclk   = 1'b0;
  logic        reset  = 1'b1;
  logic        record = 1'b0;
  logic        adclrc = 1'b1;
  logic        adcdat = 1'b0;
  wire  [17:0] addr;
  wire  [15:0] data;
  logic        write;
  logic        full;

  adc_rec dut (
    .bclk   (bclk),
    .reset  (reset),
    .record (record),
    .adclrc (adclrc),
    .adcdat (adcdat),
    .addr   (addr),
    .data   (data),
    .write  (write),
    .full   (full)
  );

  always #5 bclk = ~bclk;

  int cyc = 0;
  always @(posedge bclk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // recorder model: every complete left frame while recording lands at the next free word
  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [17:0] m_addr = 18'd0;
  logic        m_full = 1'b0;
  int          n_writes = 0;
  int          last_wr_cyc = 0;
  int          frame_cyc = 0;
  logic [17:0] last_wr_addr = 18'd0;
  logic [15:0] last_wr_data = 16'd0;

  function automatic void expect_write(input logic [15:0] w);
    if (!m_full) begin
      exp_q.push_back({m_addr, w});
      if (m_addr == 18'h3FFFF) m_full = 1'b1;
      else                     m_addr = m_addr + 18'd1;
    end
  endfunction

  logic        prev_wr = 1'b0;
  logic [17:0] prev_addr = 18'd0;
  wr_t         e;

  initial forever begin
    @(negedge bclk);
    if (prev_wr && record && !reset) begin
      if (prev_addr == 18'h3FFFF) check("addr_nowrap", 32'(addr), 32'h3FFFF);
      else                        check("addr_inc", 32'(addr), 32'(prev_addr + 18'd1));
      check("strobe_len", 32'(write), 32'd0);
    end
    prev_wr   = write;
    prev_addr = addr;
    if (write === 1'b1) begin
      n_writes++;
      last_wr_cyc  = cyc;
      last_wr_addr = addr;
      last_wr_data = data;
      check("wr_gate", 32'({record, full}), 32'b10);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write (cycle %0d)", addr, data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(addr), 32'(e.a));
        check("wr_data", 32'(data), 32'(e.d));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge bclk); #1;
    reset = 1'b1; record = 1'b0; adclrc = 1'b1; adcdat = 1'b0;
    repeat (3) @(negedge bclk);
    #1 reset = 1'b0;
    m_addr = 18'd0; m_full = 1'b0; n_writes = 0;
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge bclk); #1;
      adclrc = 1'b1; adcdat = 1'b0;
    end
  endtask

  // slot 0: L/R change, slot 1: I2S delay bit (driven as ~MSB), slots 2..17: MSB..LSB
  task automatic send_half(input logic lrc, input logic [15:0] w, input int rise_at,
                           input int fall_at, input int nslots);
    logic [15:0] sh;
    sh = w;
    for (int k = 0; k < nslots; k++) begin
      @(negedge bclk); #1;
      if (k == rise_at) record = 1'b1;
      if (k == fall_at) record = 1'b0;
      adclrc = lrc;
      if (k == 1) begin
        adcdat = ~w[15];
      end else if (k >= 2 && k < 18) begin
        adcdat = sh[15];
        sh = {sh[14:0], 1'b0};
      end else begin
        adcdat = 1'b0;
      end
      if (!lrc && k == 0) frame_cyc = cyc + 1;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic exp_wr,
                            input int rise_at, input int fall_at);
    if (exp_wr) expect_write(l);
    send_half(1'b0, l, rise_at, fall_at, 32);
    send_half(1'b1, r, -1, -1, 32);
  endtask

  initial begin
    // single frame, reset state and latency
    do_reset();
    check("rst_write", 32'(write), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    @(negedge bclk); #1 record = 1'b1;
    @(negedge bclk);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    idle(4);
    send_frame(16'hA5C3, 16'h1234, 1'b1, -1, -1);
    check("s1_latency", 32'(last_wr_cyc - frame_cyc), 32'd17);
    check("s1_count", 32'(n_writes), 32'd1);
    check("s1_wr_addr", 32'(last_wr_addr), 32'd0);
    check("s1_wr_data", 32'(last_wr_data), 32'hA5C3);
    check("s1_addr_after", 32'(addr), 32'd1);
    check("s1_drained", 32'(exp_q.size()), 32'd0);

    // three back-to-back frames, right channel ignored
    do_reset();
    @(negedge bclk); #1 record = 1'b1;
    idle(4);
    send_frame(16'h0001, 16'h1234, 1'b1, -1, -1);
    send_frame(16'h8000, 16'h1234, 1'b1, -1, -1);
    send_frame(16'hFFFF, 16'h1234, 1'b1, -1, -1);
    check("s2_count", 32'(n_writes), 32'd3);
    check("s2_last_addr", 32'(last_wr_addr), 32'd2);
    check("s2_last_data", 32'(last_wr_data), 32'hFFFF);
    check("s2_addr_after", 32'(addr), 32'd3);
    check("s2_drained", 32'(exp_q.size()), 32'd0);

    // record rises mid left frame: that frame is skipped
    do_reset();
    idle(4);
    send_frame(16'h1111, 16'h1234, 1'b0, 8, -1);
    send_frame(16'h2222, 16'h1234, 1'b1, -1, -1);
    check("s3_count", 32'(n_writes), 32'd1);
    check("s3_wr_addr", 32'(last_wr_addr), 32'd0);
    check("s3_wr_data", 32'(last_wr_data), 32'h2222);
    check("s3_addr_after", 32'(addr), 32'd1);

    // record drops after 8 bits, then resumes at the same address
    send_frame(16'h3333, 16'h1234, 1'b0, -1, 10);
    check("s4_no_write", 32'(n_writes), 32'd1);
    @(negedge bclk); #1 record = 1'b1;
    idle(4);
    check("s4_addr_kept", 32'(addr), 32'd1);
    send_frame(16'h4444, 16'h1234, 1'b1, -1, -1);
    check("s4_count", 32'(n_writes), 32'd2);
    check("s4_wr_addr", 32'(last_wr_addr), 32'd1);
    check("s4_wr_data", 32'(last_wr_data), 32'h4444);
    check("s4_drained", 32'(exp_q.size()), 32'd0);

    // end of memory: two writes, full, third frame dropped
    do_reset();
    @(negedge bclk); #1 force dut.addr_q = 18'h3FFFE;
    @(negedge bclk); #1 release dut.addr_q;
    m_addr = 18'h3FFFE;
    record = 1'b1;
    @(negedge bclk);
    check("s5_preload", 32'(addr), 32'h3FFFE);
    idle(4);
    send_frame(16'h5555, 16'h1234, 1'b1, -1, -1);
    send_frame(16'h6666, 16'h1234, 1'b1, -1, -1);
    check("s5_full", 32'(full), 32'd1);
    check("s5_last_addr", 32'(last_wr_addr), 32'h3FFFF);
    send_frame(16'h7777, 16'h1234, 1'b1, -1, -1);
    check("s5_count", 32'(n_writes), 32'd2);
    check("s5_addr_stuck", 32'(addr), 32'h3FFFF);
    check("s5_full_model", 32'(full), 32'(m_full));
    check("s5_drained", 32'(exp_q.size()), 32'd0);

    // reset during the STORE cycle suppresses the write
    do_reset();
    check("s6_rst_full", 32'(full), 32'd0);
    @(negedge bclk); #1 record = 1'b1;
    idle(4);
    send_frame(16'h8181, 16'h1234, 1'b1, -1, -1);
    check("s6_addr_pre", 32'(addr), 32'd1);
    send_half(1'b0, 16'h9999, -1, -1, 18);
    @(posedge bclk); #1 reset = 1'b1;
    @(negedge bclk);
    check("s6_write_blocked", 32'(write), 32'd0);
    @(posedge bclk); #1;
    check("s6_addr_rst", 32'(addr), 32'd0);
    check("s6_full_rst", 32'(full), 32'd0);
    check("s6_count", 32'(n_writes), 32'd1);
    @(negedge bclk); #1 reset = 1'b0;
    m_addr = 18'd0; m_full = 1'b0;
    idle(4);
    send_frame(16'hBEEF, 16'h1234, 1'b1, -1, -1);
    check("s6_resume_addr", 32'(last_wr_addr), 32'd0);
    check("s6_resume_data", 32'(last_wr_data), 32'hBEEF);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
